// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage_pkg
//  Description : Shared control encodings for the EX operand stage:
//                immediate-extension selectors, ALU opcodes and the
//                field widths used across the ID/EX boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_operand_stage_pkg;

    // Field widths of the ID/EX instruction fields
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int ALUOP_W = 4;
    localparam int EXTOP_W = 2;

    // Immediate extension selector; the reserved code behaves like zero-extend
    typedef enum logic [EXTOP_W-1:0] {
        EXTOP_ZERO = 2'b00,
        EXTOP_SIGN = 2'b01,
        EXTOP_LUI  = 2'b10,
        EXTOP_RSVD = 2'b11
    } extop_e;

    // ALU operation codes; every 4-bit value is named so a cast is total
    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD  = 4'h0,
        ALUOP_SUB  = 4'h1,
        ALUOP_AND  = 4'h2,
        ALUOP_OR   = 4'h3,
        ALUOP_XOR  = 4'h4,
        ALUOP_NOR  = 4'h5,
        ALUOP_SLT  = 4'h6,
        ALUOP_SLTU = 4'h7,
        ALUOP_SLL  = 4'h8,
        ALUOP_SRL  = 4'h9,
        ALUOP_SRA  = 4'hA,
        ALUOP_SLLV = 4'hB,
        ALUOP_SRLV = 4'hC,
        ALUOP_SRAV = 4'hD,
        ALUOP_LUI  = 4'hE,
        ALUOP_PASS = 4'hF
    } aluop_e;

    // Register index that is hard-wired to zero and never forwarded
    localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Operand forwarding selector for one EX source register.
//                EX/MEM producer wins over MEM/WB; register 0 is never
//                forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_W-1:0] ex_reg,
    input  logic [XLEN-1:0]  reg_data,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  fwd_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = mem_regwrite && (mem_rd != ZERO_REG) && (mem_rd == ex_reg);
    assign w_wb_hit  = wb_regwrite  && (wb_rd  != ZERO_REG) && (wb_rd  == ex_reg);

    // Pick the youngest in-flight producer of the register, else the latched value
    always_comb begin
        fwd_data = reg_data;
        if (w_mem_hit) begin
            fwd_data = mem_result;
        end else if (w_wb_hit) begin
            fwd_data = wb_result;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage
//  Description : ID/EX pipeline latch with immediate extension, operand
//                forwarding from EX/MEM and MEM/WB, and load-use hazard
//                detection against the instruction currently in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 id_alusrc,
    input  logic [EXTOP_W-1:0]   id_extop,
    input  logic [XLEN-1:0]      id_rs_data,
    input  logic [XLEN-1:0]      id_rt_data,
    input  logic [REG_W-1:0]     id_rs,
    input  logic [REG_W-1:0]     id_rt,
    input  logic [REG_W-1:0]     id_rd,
    input  logic [REG_W-1:0]     id_shamt,
    input  logic [IMM_W-1:0]     id_imm,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic                 mem_regwrite,
    input  logic [REG_W-1:0]     mem_rd,
    input  logic [XLEN-1:0]      mem_result,
    input  logic                 wb_regwrite,
    input  logic [REG_W-1:0]     wb_rd,
    input  logic [XLEN-1:0]      wb_result,
    output logic [XLEN-1:0]      busA,
    output logic [XLEN-1:0]      busB,
    output logic [ALUOP_W-1:0]   ALUop,
    output logic [REG_W-1:0]     s,
    output logic [XLEN-1:0]      ex_store_data,
    output logic [REG_W-1:0]     ex_rd,
    output logic                 ex_valid,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    output logic                 load_use_hazard
);

    // EX latch contents
    logic               r_valid;
    logic               r_regwrite;
    logic               r_memread;
    logic               r_alusrc;
    logic [XLEN-1:0]    r_rs_data;
    logic [XLEN-1:0]    r_rt_data;
    logic [REG_W-1:0]   r_rs;
    logic [REG_W-1:0]   r_rt;
    logic [REG_W-1:0]   r_rd;
    logic [REG_W-1:0]   r_shamt;
    logic [XLEN-1:0]    r_imm_ext;
    aluop_e             r_aluop;

    logic [XLEN-1:0]    w_imm_ext;
    logic [XLEN-1:0]    w_imm_zext;
    logic [XLEN-1:0]    w_rs_fwd;
    logic [XLEN-1:0]    w_rt_fwd;
    logic               w_rd_match;

    assign w_imm_zext = {{(XLEN-IMM_W){1'b0}}, id_imm};

    // Extend the ID immediate so the latch holds the final operand value
    always_comb begin
        w_imm_ext = w_imm_zext;
        case (id_extop)
            EXTOP_SIGN: w_imm_ext = {{(XLEN-IMM_W){id_imm[IMM_W-1]}}, id_imm};
            EXTOP_LUI:  w_imm_ext = w_imm_zext << IMM_W;
            default:    w_imm_ext = w_imm_zext;
        endcase
    end

    // ID/EX latch: flush inserts a bubble (even under stall), stall holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_alusrc   <= 1'b0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_shamt    <= '0;
            r_imm_ext  <= '0;
            r_aluop    <= ALUOP_ADD;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_alusrc   <= 1'b0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_shamt    <= '0;
            r_imm_ext  <= '0;
            r_aluop    <= ALUOP_ADD;
        end else if (!stall) begin
            r_valid    <= id_valid;
            r_regwrite <= id_regwrite;
            r_memread  <= id_memread;
            r_alusrc   <= id_alusrc;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rd       <= id_rd;
            r_shamt    <= id_shamt;
            r_imm_ext  <= w_imm_ext;
            r_aluop    <= aluop_e'(id_aluop);
        end
    end

    fwd_mux #(
        .XLEN         (XLEN)
    ) u_fwd_rs (
        .ex_reg       (r_rs),
        .reg_data     (r_rs_data),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .fwd_data     (w_rs_fwd)
    );

    fwd_mux #(
        .XLEN         (XLEN)
    ) u_fwd_rt (
        .ex_reg       (r_rt),
        .reg_data     (r_rt_data),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .fwd_data     (w_rt_fwd)
    );

    // Store data always carries rt, even when busB is the immediate
    assign busA          = w_rs_fwd;
    assign busB          = r_alusrc ? r_imm_ext : w_rt_fwd;
    assign ex_store_data = w_rt_fwd;

    // Control outputs straight from the latch; write/read strobes gated by valid
    assign ALUop       = r_aluop;
    assign s           = r_shamt;
    assign ex_rd       = r_rd;
    assign ex_valid    = r_valid;
    assign ex_regwrite = r_valid & r_regwrite;
    assign ex_memread  = r_valid & r_memread;

    // A load in EX feeding the instruction in ID cannot be forwarded in time
    assign w_rd_match      = (r_rd == id_rs) || (r_rd == id_rt);
    assign load_use_hazard = ex_memread && (r_rd != ZERO_REG) && id_valid && w_rd_match;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_operand_stage
//  Description : Scoreboard bench for ex_operand_stage with a transaction
//                level reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

    typedef struct {
        logic        stall, flush;
        logic        valid, regwrite, memread, alusrc;
        logic [1:0]  extop;
        logic [31:0] rs_data, rt_data;
        logic [4:0]  rs, rt, rd, shamt;
        logic [15:0] imm;
        logic [3:0]  aluop;
        logic        mem_rw;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
    } stim_t;

    typedef struct {
        logic [31:0] bus_a, bus_b, store;
        logic [3:0]  aluop;
        logic [4:0]  sh, rd;
        logic        valid, regwrite, memread, hazard;
    } exp_t;

    logic        clk, rst_n, stall, flush;
    logic        id_valid, id_regwrite, id_memread, id_alusrc;
    logic [1:0]  id_extop;
    logic [31:0] id_rs_data, id_rt_data;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm;
    logic [3:0]  id_aluop;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [31:0] busA, busB, ex_store_data;
    logic [3:0]  ALUop;
    logic [4:0]  s, ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, load_use_hazard;

    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];
    stim_t model_ex;
    exp_t  mon_e;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_alusrc(id_alusrc), .id_extop(id_extop),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_imm(id_imm), .id_aluop(id_aluop),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .busA(busA), .busB(busB), .ALUop(ALUop), .s(s),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .load_use_hazard(load_use_hazard)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t zero_stim();
        stim_t z;
        z = '{default: '0};
        return z;
    endfunction

    // Architectural view of the immediate
    function automatic logic [31:0] ext_imm(logic [15:0] imm, logic [1:0] op);
        int v;
        if (op == 2'b01) begin
            v = int'(signed'(imm));
            return 32'(v);
        end
        if (op == 2'b10) return 32'(imm) * 32'd65536;
        return 32'(imm);
    endfunction

    // Newest writer of a nonzero register supplies its value
    function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] d, stim_t f);
        if (r == 0) return d;
        if (f.mem_rw && f.mem_rd == r) return f.mem_res;
        if (f.wb_rw && f.wb_rd == r) return f.wb_res;
        return d;
    endfunction

    function automatic exp_t predict(stim_t m, stim_t cur);
        exp_t e;
        logic [31:0] rtv;
        rtv        = operand(m.rt, m.rt_data, cur);
        e.bus_a    = operand(m.rs, m.rs_data, cur);
        e.bus_b    = m.alusrc ? ext_imm(m.imm, m.extop) : rtv;
        e.store    = rtv;
        e.aluop    = m.aluop;
        e.sh       = m.shamt;
        e.rd       = m.rd;
        e.valid    = m.valid;
        e.regwrite = m.valid && m.regwrite;
        e.memread  = m.valid && m.memread;
        e.hazard   = m.valid && m.memread && m.rd != 0 && cur.valid &&
                     (m.rd == cur.rs || m.rd == cur.rt);
        return e;
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the expected response
    task automatic apply(input stim_t t);
        @(negedge clk);
        stall = t.stall; flush = t.flush;
        id_valid = t.valid; id_regwrite = t.regwrite; id_memread = t.memread;
        id_alusrc = t.alusrc; id_extop = t.extop;
        id_rs_data = t.rs_data; id_rt_data = t.rt_data;
        id_rs = t.rs; id_rt = t.rt; id_rd = t.rd; id_shamt = t.shamt;
        id_imm = t.imm; id_aluop = t.aluop;
        mem_regwrite = t.mem_rw; mem_rd = t.mem_rd; mem_result = t.mem_res;
        wb_regwrite = t.wb_rw; wb_rd = t.wb_rd; wb_result = t.wb_res;
        if (t.flush) model_ex = zero_stim();
        else if (!t.stall) model_ex = t;
        sb.push_back(predict(model_ex, t));
    endtask

    function automatic stim_t rand_stim();
        stim_t r;
        r.stall    = ($urandom_range(0, 9) < 2);
        r.flush    = ($urandom_range(0, 9) < 1);
        r.valid    = ($urandom_range(0, 9) < 8);
        r.regwrite = 1'($urandom);
        r.memread  = 1'($urandom);
        r.alusrc   = 1'($urandom);
        r.extop    = 2'($urandom);
        r.rs_data  = $urandom;
        r.rt_data  = $urandom;
        r.rs       = 5'($urandom_range(0, 7));
        r.rt       = 5'($urandom_range(0, 7));
        r.rd       = 5'($urandom_range(0, 7));
        r.shamt    = 5'($urandom);
        r.imm      = 16'($urandom);
        r.aluop    = 4'($urandom);
        r.mem_rw   = 1'($urandom);
        r.mem_rd   = 5'($urandom_range(0, 7));
        r.mem_res  = $urandom;
        r.wb_rw    = 1'($urandom);
        r.wb_rd    = 5'($urandom_range(0, 7));
        r.wb_res   = $urandom;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busA"}, busA, 0);
        chk({tag, "_busB"}, busB, 0);
        chk({tag, "_ALUop"}, 32'(ALUop), 0);
        chk({tag, "_s"}, 32'(s), 0);
        chk({tag, "_store"}, ex_store_data, 0);
        chk({tag, "_rd"}, 32'(ex_rd), 0);
        chk({tag, "_ctrl"}, {28'd0, ex_valid, ex_regwrite, ex_memread, load_use_hazard}, 0);
    endtask

    // Monitor: compare every queued expectation just after the active edge
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("busA", busA, mon_e.bus_a);
            chk("busB", busB, mon_e.bus_b);
            chk("store_data", ex_store_data, mon_e.store);
            chk("ALUop", 32'(ALUop), 32'(mon_e.aluop));
            chk("s", 32'(s), 32'(mon_e.sh));
            chk("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
            chk("ex_valid", 32'(ex_valid), 32'(mon_e.valid));
            chk("ex_regwrite", 32'(ex_regwrite), 32'(mon_e.regwrite));
            chk("ex_memread", 32'(ex_memread), 32'(mon_e.memread));
            chk("load_use_hazard", 32'(load_use_hazard), 32'(mon_e.hazard));
        end
    end

    initial begin
        stim_t t;
        rst_n = 1'b0;
        model_ex = zero_stim();
        t = zero_stim();
        stall = 0; flush = 0; id_valid = 0; id_regwrite = 0; id_memread = 0;
        id_alusrc = 0; id_extop = 0; id_rs_data = 0; id_rt_data = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_imm = 0; id_aluop = 0;
        mem_regwrite = 0; mem_rd = 0; mem_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_result = 0;

        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Sign-extended immediate on busB, rs data on busA
        t = zero_stim();
        t.valid = 1; t.rs = 5; t.rs_data = 32'h10; t.imm = 16'hFFFF;
        t.extop = 2'b01; t.alusrc = 1;
        apply(t);
        @(posedge clk); #2;
        chk("dir_busA_rs5", busA, 32'h10);
        chk("dir_busB_sext", busB, 32'hFFFF_FFFF);

        // MEM wins over WB, then WB alone
        t = zero_stim();
        t.valid = 1; t.rs = 3; t.rs_data = 32'h1234;
        t.mem_rw = 1; t.mem_rd = 3; t.mem_res = 32'hAA;
        t.wb_rw = 1; t.wb_rd = 3; t.wb_res = 32'hBB;
        apply(t);
        @(posedge clk); #2;
        chk("dir_fwd_mem_prio", busA, 32'hAA);
        t.stall = 1; t.mem_rw = 0;
        apply(t);
        @(posedge clk); #2;
        chk("dir_fwd_wb", busA, 32'hBB);

        // Register 0 never forwarded
        t = zero_stim();
        t.valid = 1; t.rs = 0; t.rs_data = 0;
        t.mem_rw = 1; t.mem_rd = 0; t.mem_res = 32'h55;
        apply(t);
        @(posedge clk); #2;
        chk("dir_no_fwd_r0", busA, 32'h0);

        // Load-use: lw rd=8 in EX, consumer rt=8 in ID while stalled, then flush
        t = zero_stim();
        t.valid = 1; t.regwrite = 1; t.memread = 1; t.rd = 8; t.rs = 2;
        t.rs_data = 32'h400; t.imm = 16'h0004; t.alusrc = 1; t.aluop = 4'h0;
        apply(t);
        t = zero_stim();
        t.stall = 1; t.valid = 1; t.regwrite = 1; t.rs = 1; t.rt = 8; t.rd = 9; t.aluop = 4'h3;
        apply(t);
        @(posedge clk); #2;
        chk("dir_load_use", 32'(load_use_hazard), 32'd1);
        chk("dir_stall_rd", 32'(ex_rd), 32'd8);
        chk("dir_stall_memread", 32'(ex_memread), 32'd1);
        t.stall = 0; t.flush = 1;
        apply(t);
        @(posedge clk); #2;
        chk("dir_flush_valid", 32'(ex_valid), 32'd0);

        // Flush overrides stall
        t = zero_stim();
        t.valid = 1; t.regwrite = 1; t.rd = 4;
        apply(t);
        t.stall = 1; t.flush = 1;
        apply(t);
        @(posedge clk); #2;
        chk("dir_flush_over_stall", 32'(ex_regwrite), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            apply(rand_stim());
        end

        // Asynchronous reset between edges with a valid load latched
        t = zero_stim();
        t.valid = 1; t.regwrite = 1; t.memread = 1; t.rd = 9; t.rs = 6; t.rt = 9;
        t.rs_data = 32'hDEAD_0001; t.rt_data = 32'hBEEF_0002; t.shamt = 5'd7;
        t.aluop = 4'hC; t.imm = 16'h8001; t.extop = 2'b10; t.alusrc = 1;
        apply(t);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_ex = zero_stim();
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(rand_stim());
        end

        @(posedge clk); #3;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports stall and flush, input, 1 each, hold / bubble request from hazard control.
REQ-005 SHALL have ports id_valid, id_regwrite, id_memread and id_alusrc, input, 1 each: ID-stage instruction valid, writes register, is load, selects immediate for busB.
REQ-006 SHALL have port id_extop, input, 2: 00 zero-extend, 01 sign-extend, 10 LUI (imm<<16), 11 treated as 00.
REQ-007 SHALL have ports id_rs_data and id_rt_data, input, XLEN each: register file read data.
REQ-008 SHALL have ports id_rs, id_rt, id_rd and id_shamt, input, 5 each.
REQ-009 SHALL have ports id_imm, input, 16, and id_aluop, input, 4, ALU operation code.
REQ-010 SHALL have forwarding ports mem_regwrite (1), mem_rd (5) and mem_result (XLEN), input, EX/MEM producer.
REQ-011 SHALL have forwarding ports wb_regwrite (1), wb_rd (5) and wb_result (XLEN), input, MEM/WB producer.
REQ-012 SHALL have outputs busA and busB, XLEN each, ALU operands.
REQ-013 SHALL have outputs ALUop (4) and s (5), ALU opcode and shift amount.
REQ-014 SHALL have outputs ex_store_data (XLEN), ex_rd (5), and ex_valid, ex_regwrite, ex_memread (1 each).
REQ-015 SHALL have output load_use_hazard, 1.

Function
REQ-016 SHALL register all id_* fields into the EX latch on each rising clk edge when stall=0 and flush=0.
REQ-017 SHALL load a bubble when flush=1 (valid, regwrite, memread=0; data fields 0); flush SHALL override stall.
REQ-018 SHALL hold all latch contents when stall=1 and flush=0.
REQ-019 SHALL form the extended immediate at latch time per id_extop.
REQ-020 SHALL compute the forwarded rs value combinationally: if mem_regwrite, mem_rd!=0 and mem_rd==ex_rs, take mem_result; else if wb_regwrite, wb_rd!=0 and wb_rd==ex_rs, take wb_result; else take the latched rs data. Rt SHALL be forwarded identically.
REQ-021 SHALL give MEM priority over WB when both match; register 0 SHALL never be forwarded.
REQ-022 SHALL drive busA = forwarded rs; busB = extended immediate if latched alusrc=1, else forwarded rt.
REQ-023 SHALL drive ex_store_data = forwarded rt regardless of alusrc.
REQ-024 SHALL drive ALUop, s, ex_rd, ex_regwrite, ex_memread and ex_valid directly from the latch, with one-cycle latency from ID.
REQ-025 SHALL assert load_use_hazard combinationally when ex_valid, ex_memread, ex_rd!=0, id_valid, and (ex_rd==id_rs or ex_rd==id_rt).
REQ-026 SHALL gate ex_regwrite and ex_memread with ex_valid.

Reset
REQ-027 SHALL, while rst_n=0, clear every latch field to 0 asynchronously, making busA, busB, ALUop, s, ex_rd, ex_store_data = 0 and ex_valid, ex_regwrite, ex_memread, load_use_hazard = 0 when no forward matches.
REQ-028 SHALL restart on the first rising edge after rst_n deasserts; an assertion mid-operation SHALL discard the latched instruction.

Structure
REQ-029 SHALL take the extop encodings and ALUop codes from the shared control-encoding definitions package; XLEN SHALL stay local.
REQ-030 SHALL implement the forwarding selection as one sub-module, fwd_mux, instantiated twice (rs and rt).

Verification
REQ-031 The bench SHALL check: id rs=5, data 0x10, imm=0xFFFF, extop=01, alusrc=1, no forwards, then one clk -> busA=0x10, busB=0xFFFFFFFF.
REQ-032 The bench SHALL check: ex_rs=3, mem_regwrite=1, mem_rd=3, mem_result=0xAA, wb_regwrite=1, wb_rd=3, wb_result=0xBB -> busA=0xAA; with mem_regwrite=0 -> busA=0xBB.
REQ-033 The bench SHALL check: mem_rd=0, mem_regwrite=1, mem_result=0x55, ex_rs=0, latched rs data 0 -> busA=0.
REQ-034 The bench SHALL check: ex latched lw with rd=8, id_valid=1, id_rt=8 -> load_use_hazard=1; with stall=1 for one clk the latch is unchanged; then flush=1 gives ex_valid=0 next cycle.
REQ-035 The bench SHALL check: stall=1 and flush=1 together -> bubble latched (ex_regwrite=0).
REQ-036 The bench SHALL check: rst_n pulled low between edges with a valid instruction latched -> all outputs 0 immediately, without waiting for clk.
